// File: rtl/gb_apu_pkg.sv
// Shared frame-sequencer constants: step width, per-step strobe masks and the step type.
package gb_apu_pkg;

  localparam int FS_STEP_W = 3;

  // Bit n of each mask says whether executing step n fires that unit.
  localparam logic [7:0] FS_LENGTH_MASK = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_MASK  = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_MASK    = 8'b1000_0000;

  typedef logic [FS_STEP_W-1:0] fs_step_t;

endpackage

// File: rtl/gb_apu_frame_sequencer_if.sv
// Frame-sequencer bus: timer-side inputs and the modulation-unit strobes.
interface gb_apu_frame_sequencer_if
  import gb_apu_pkg::*;
#(
  parameter int DIV_W = 16
);

  logic             apu_enable;
  logic             double_speed;
  logic [DIV_W-1:0] div_counter;
  logic             clk_length_ctr;
  logic             clk_sweep;
  logic             clk_envelope;
  fs_step_t         step;
  logic             length_pending;

  modport master (
    output apu_enable,
    output double_speed,
    output div_counter,
    input  clk_length_ctr,
    input  clk_sweep,
    input  clk_envelope,
    input  step,
    input  length_pending
  );

  modport slave (
    input  apu_enable,
    input  double_speed,
    input  div_counter,
    output clk_length_ctr,
    output clk_sweep,
    output clk_envelope,
    output step,
    output length_pending
  );

endinterface

// File: rtl/gb_apu_falling_edge.sv
// Registers the DIV tap and flags its 1->0 transitions combinationally in the current cycle.
module gb_apu_falling_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic div_prev;

  // Tracks the tap every cycle, independent of APU power, so a re-enable never sees a stale edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= in;
    end
  end

  assign pulse = div_prev & ~in;

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// 512 Hz APU frame sequencer: walks an 8-step pattern on DIV-bit falling edges and emits
// single-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) strobes.
module gb_apu_frame_sequencer
  import gb_apu_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_BIT = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  gb_apu_frame_sequencer_if.slave  bus
);

  localparam int TAP_HI = DIV_BIT + 1;

  logic     tap_p0;
  logic     tick_p0;
  fs_step_t step_q;
  logic     length_p1;
  logic     sweep_p1;
  logic     env_p1;

  assign tap_p0 = bus.double_speed ? bus.div_counter[TAP_HI] : bus.div_counter[DIV_BIT];

  gb_apu_falling_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (tap_p0),
    .pulse (tick_p0)
  );

  // ---- stage p0 -> p1: strobes decode the step being executed, then step advances
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q    <= '0;
      length_p1 <= 1'b0;
      sweep_p1  <= 1'b0;
      env_p1    <= 1'b0;
    end else if (!bus.apu_enable) begin
      // Powered off: pattern parked at step 0, and a coincident tick is dropped.
      step_q    <= '0;
      length_p1 <= 1'b0;
      sweep_p1  <= 1'b0;
      env_p1    <= 1'b0;
    end else if (tick_p0) begin
      step_q    <= step_q + 1'b1;
      length_p1 <= FS_LENGTH_MASK[step_q];
      sweep_p1  <= FS_SWEEP_MASK[step_q];
      env_p1    <= FS_ENV_MASK[step_q];
    end else begin
      length_p1 <= 1'b0;
      sweep_p1  <= 1'b0;
      env_p1    <= 1'b0;
    end
  end

  assign bus.clk_length_ctr = length_p1;
  assign bus.clk_sweep      = sweep_p1;
  assign bus.clk_envelope   = env_p1;
  assign bus.step           = step_q;
  assign bus.length_pending = FS_LENGTH_MASK[step_q];

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Directed testbench for gb_apu_frame_sequencer with hand-computed strobe/step expectations.
module tb_gb_apu_frame_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  gb_apu_frame_sequencer_if #(.DIV_W(16)) bus ();

  gb_apu_frame_sequencer #(.DIV_W(16), .DIV_BIT(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_bit(input int b);
    bus.div_counter    = 16'h0000;
    bus.div_counter[b] = 1'b1;
    cyc();
    bus.div_counter[b] = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    bus.apu_enable   = 1'b1;
    bus.double_speed = 1'b0;
    bus.div_counter  = 16'h0000;
    cyc();
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, expected 000", {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope});
    end
    checks++;
    if (bus.step !== 3'd0) begin
      errors++;
      $display("FAIL reset_step: got %0d, expected 0", bus.step);
    end
    checks++;
    if (bus.length_pending !== 1'b1) begin
      errors++;
      $display("FAIL reset_length_pending: got %b, expected 1", bus.length_pending);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_pattern();
    logic [2:0] exp_strb [8] = '{3'b100, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001};
    logic [2:0] exp_step [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       exp_lp   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      pulse_bit(12);
      checks++;
      if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== exp_strb[i]) begin
        errors++;
        $display("FAIL pattern_strobes tick %0d: got %b, expected %b", i + 1,
                 {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, exp_strb[i]);
      end
      checks++;
      if (bus.step !== exp_step[i] || bus.length_pending !== exp_lp[i]) begin
        errors++;
        $display("FAIL pattern_step tick %0d: got step %0d lp %b, expected step %0d lp %b", i + 1,
                 bus.step, bus.length_pending, exp_step[i], exp_lp[i]);
      end
      cyc();
      checks++;
      if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000) begin
        errors++;
        $display("FAIL pattern_strobe_width tick %0d: got %b, expected 000", i + 1,
                 {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope});
      end
    end
  endtask

  task automatic test_single_edge();
    int n_strobe;
    n_strobe = 0;
    bus.div_counter = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.clk_length_ctr) n_strobe++;
    end
    bus.div_counter = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.clk_length_ctr) n_strobe++;
    end
    checks++;
    if (n_strobe !== 0 || bus.step !== 3'd0) begin
      errors++;
      $display("FAIL low_and_rising_quiet: got %0d strobes step %0d, expected 0 strobes step 0", n_strobe, bus.step);
    end
    bus.div_counter = 16'h0000;
    cyc();
    checks++;
    if (bus.clk_length_ctr !== 1'b1) begin
      errors++;
      $display("FAIL edge_latency: got length %b one clk after edge, expected 1", bus.clk_length_ctr);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.clk_length_ctr) n_strobe++;
    end
    checks++;
    if (n_strobe !== 0 || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL single_strobe: got %0d extra strobes step %0d, expected 0 extra step 1", n_strobe, bus.step);
    end
  endtask

  task automatic test_double_speed();
    bus.div_counter  = 16'h0000;
    bus.double_speed = 1'b1;
    cyc();
    pulse_bit(12);
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL ds_bit12_ignored: got strobes %b step %0d, expected 000 step 1",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    pulse_bit(13);
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd2) begin
      errors++;
      $display("FAIL ds_bit13_step1: got strobes %b step %0d, expected 000 step 2",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    pulse_bit(13);
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b110 || bus.step !== 3'd3) begin
      errors++;
      $display("FAIL ds_bit13_step2: got strobes %b step %0d, expected 110 step 3",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    bus.double_speed = 1'b0;
    cyc();
  endtask

  task automatic test_disable();
    int n_strobe;
    n_strobe = 0;
    pulse_bit(12);
    pulse_bit(12);
    checks++;
    if (bus.step !== 3'd5) begin
      errors++;
      $display("FAIL disable_setup: got step %0d, expected 5", bus.step);
    end
    bus.apu_enable = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      pulse_bit(12);
      if (bus.clk_length_ctr | bus.clk_sweep | bus.clk_envelope) n_strobe++;
      if (bus.step !== 3'd0) n_strobe++;
    end
    checks++;
    if (n_strobe !== 0) begin
      errors++;
      $display("FAIL disabled_quiet: got %0d strobe/step violations, expected 0", n_strobe);
    end
    bus.div_counter = 16'h1000;
    cyc();
    bus.apu_enable = 1'b1;
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd0) begin
      errors++;
      $display("FAIL enable_cycle: got strobes %b step %0d, expected 000 step 0",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    bus.div_counter = 16'h0000;
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b100 || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL reenable_first_tick: got strobes %b step %0d, expected 100 step 1",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    pulse_bit(12);
    bus.div_counter = 16'h1000;
    cyc();
    bus.div_counter = 16'h0000;
    bus.apu_enable  = 1'b0;
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd0) begin
      errors++;
      $display("FAIL tick_vs_disable: got strobes %b step %0d, expected 000 step 0",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    bus.apu_enable = 1'b1;
    cyc();
  endtask

  task automatic test_div_write();
    bus.div_counter = 16'h1000;
    cyc();
    bus.div_counter = 16'h0000;
    cyc();
    checks++;
    if (bus.clk_length_ctr !== 1'b1 || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL div_clear_tick: got length %b step %0d, expected 1 step 1", bus.clk_length_ctr, bus.step);
    end
    bus.div_counter = 16'h0FFF;
    cyc();
    bus.div_counter = 16'h0000;
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL div_clear_no_tick: got strobes %b step %0d, expected 000 step 1",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
    bus.div_counter = 16'h1000;
    cyc();
    bus.double_speed = 1'b1;
    cyc();
    checks++;
    if (bus.step !== 3'd2) begin
      errors++;
      $display("FAIL ds_toggle_tick: got step %0d, expected 2", bus.step);
    end
    bus.div_counter  = 16'h0000;
    bus.double_speed = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) pulse_bit(12);
    checks++;
    if (bus.step !== 3'd7) begin
      errors++;
      $display("FAIL reset_mid_setup: got step %0d, expected 7", bus.step);
    end
    bus.div_counter = 16'h1000;
    cyc();
    bus.div_counter = 16'h0000;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.step !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got step %0d, expected 0", bus.step);
    end
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd0 ||
        bus.length_pending !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_held: got strobes %b step %0d lp %b, expected 000 step 0 lp 1",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step, bus.length_pending);
    end
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if ({bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope} !== 3'b000 || bus.step !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_release: got strobes %b step %0d, expected 000 step 0",
               {bus.clk_length_ctr, bus.clk_sweep, bus.clk_envelope}, bus.step);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_pattern();
    test_single_edge();
    test_double_speed();
    test_disable();
    test_div_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
